// File: rtl/mips_multicycle_control.sv
// mips_multicycle_control: multicycle MIPS main control FSM; define ADDI_EN to add addi support
module mips_multicycle_control #(
   parameter int COUNT_W = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [5:0]         opcode,
   input  logic               memReady,
   output logic               PCWrite,
   output logic               PCWriteCond,
   output logic               IorD,
   output logic               MemRead,
   output logic               MemWrite,
   output logic               IRWrite,
   output logic               MemtoReg,
   output logic               RegDst,
   output logic               RegWrite,
   output logic               ALUSrcA,
   output logic [1:0]         ALUSrcB,
   output logic [1:0]         ALUOp,
   output logic [1:0]         PCSource,
   output logic               illegalOp,
   output logic [3:0]         state,
   output logic [COUNT_W-1:0] instrCount
);
   localparam logic [3:0] FETCH     = 4'd0;
   localparam logic [3:0] DECODE    = 4'd1;
   localparam logic [3:0] MEM_ADDR  = 4'd2;
   localparam logic [3:0] MEM_READ  = 4'd3;
   localparam logic [3:0] MEM_WB    = 4'd4;
   localparam logic [3:0] MEM_WRITE = 4'd5;
   localparam logic [3:0] EXECUTE   = 4'd6;
   localparam logic [3:0] ALU_WB    = 4'd7;
   localparam logic [3:0] BRANCH    = 4'd8;
   localparam logic [3:0] JUMP      = 4'd9;
   localparam logic [5:0] OP_R      = 6'b000000;
   localparam logic [5:0] OP_J      = 6'b000010;
   localparam logic [5:0] OP_BEQ    = 6'b000100;
   localparam logic [5:0] OP_LW     = 6'b100011;
   localparam logic [5:0] OP_SW     = 6'b101011;
`ifdef ADDI_EN
   localparam logic [3:0] ADDI_EXEC = 4'd10;
   localparam logic [3:0] ADDI_WB   = 4'd11;
   localparam logic [5:0] OP_ADDI   = 6'b001000;
`endif

   logic [3:0] nextState;
   logic [5:0] opLatched;
   logic       retire;
   logic       illegalNext;

   // state register; reset overrides every transition including memory waits
   always_ff @(posedge clk) begin
      if (reset) state <= FETCH;
      else state <= nextState;
   end

   // opcode latch, retired-instruction counter and one-cycle illegal-opcode flag
   always_ff @(posedge clk) begin
      if (reset) begin
         opLatched  <= 6'b0;
         instrCount <= '0;
         illegalOp  <= 1'b0;
      end else begin
         illegalOp <= illegalNext;
         if (state == DECODE) opLatched <= opcode;
         if (retire) instrCount <= instrCount + COUNT_W'(1);
      end
   end

   // next-state decode; retire marks edges that complete an instruction
   always_comb begin
      nextState   = FETCH;
      retire      = 1'b0;
      illegalNext = 1'b0;
      case (state)
         FETCH:     nextState = memReady ? DECODE : FETCH;
         DECODE:
            case (opcode)
               OP_LW, OP_SW: nextState = MEM_ADDR;
               OP_R:         nextState = EXECUTE;
               OP_BEQ:       nextState = BRANCH;
               OP_J:         nextState = JUMP;
`ifdef ADDI_EN
               OP_ADDI:      nextState = ADDI_EXEC;
`endif
               default:      illegalNext = 1'b1;
            endcase
         MEM_ADDR:  nextState = (opLatched == OP_LW) ? MEM_READ : MEM_WRITE;
         MEM_READ:  nextState = memReady ? MEM_WB : MEM_READ;
         MEM_WB:    retire = 1'b1;
         MEM_WRITE: begin
            nextState = memReady ? FETCH : MEM_WRITE;
            retire    = memReady;
         end
         EXECUTE:   nextState = ALU_WB;
         ALU_WB:    retire = 1'b1;
         BRANCH:    retire = 1'b1;
         JUMP:      retire = 1'b1;
`ifdef ADDI_EN
         ADDI_EXEC: nextState = ADDI_WB;
         ADDI_WB:   retire = 1'b1;
`endif
         default:   nextState = FETCH;
      endcase
   end

   // Moore outputs; FETCH handshake gated by memReady; write/request strobes squashed in reset
   always_comb begin
      {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA} = 10'b0;
      ALUSrcB  = 2'b00;
      ALUOp    = 2'b00;
      PCSource = 2'b00;
      case (state)
         FETCH: begin
            MemRead = 1'b1;
            ALUSrcB = 2'b01;
            IRWrite = memReady;
            PCWrite = memReady;
         end
         DECODE:    ALUSrcB = 2'b11;
         MEM_ADDR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
         end
         MEM_READ: begin
            MemRead = 1'b1;
            IorD    = 1'b1;
         end
         MEM_WB: begin
            RegWrite = 1'b1;
            MemtoReg = 1'b1;
         end
         MEM_WRITE: begin
            MemWrite = 1'b1;
            IorD     = 1'b1;
         end
         EXECUTE: begin
            ALUSrcA = 1'b1;
            ALUOp   = 2'b10;
         end
         ALU_WB: begin
            RegWrite = 1'b1;
            RegDst   = 1'b1;
         end
         BRANCH: begin
            ALUSrcA     = 1'b1;
            ALUOp       = 2'b01;
            PCWriteCond = 1'b1;
            PCSource    = 2'b01;
         end
         JUMP: begin
            PCWrite  = 1'b1;
            PCSource = 2'b10;
         end
`ifdef ADDI_EN
         ADDI_EXEC: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
         end
         ADDI_WB:   RegWrite = 1'b1;
`endif
         default: ;
      endcase
      if (reset) begin
         PCWrite     = 1'b0;
         PCWriteCond = 1'b0;
         MemRead     = 1'b0;
         MemWrite    = 1'b0;
         IRWrite     = 1'b0;
         RegWrite    = 1'b0;
      end
   end
endmodule

// File: tb/tb_mips_multicycle_control.sv
// tb_mips_multicycle_control: directed self-checking bench for the multicycle MIPS control FSM
module tb_mips_multicycle_control;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [5:0] opcode = 6'b0;
   logic       memReady = 1'b0;
   logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
   logic       MemtoReg, RegDst, RegWrite, ALUSrcA, illegalOp;
   logic [1:0] ALUSrcB, ALUOp, PCSource;
   logic [3:0] state;
   logic [3:0] instrCount;
   logic [3:0] expCount = 4'd0;
   int checks = 0;
   int failures = 0;

   mips_multicycle_control #(.COUNT_W(4)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .memReady(memReady),
      .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
      .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
      .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
      .PCSource(PCSource), .illegalOp(illegalOp), .state(state), .instrCount(instrCount)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout reached");
      $fatal(1, "timeout");
   end

   task automatic test_reset();
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (state !== 4'd0) begin failures++; $display("FAIL reset_state got=%0d want=0", state); end
      checks++;
      if (instrCount !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d want=0", instrCount); end
      checks++;
      if (illegalOp !== 1'b0) begin failures++; $display("FAIL reset_illegal got=%0b want=0", illegalOp); end
      checks++;
      if ({MemRead, IRWrite, PCWrite, RegWrite, MemWrite, PCWriteCond} !== 6'b0) begin
         failures++; $display("FAIL reset_strobes got=%b want=000000", {MemRead, IRWrite, PCWrite, RegWrite, MemWrite, PCWriteCond});
      end
   endtask

   task automatic test_rtype();
      int st[5] = '{0, 1, 6, 7, 0};
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         reset = 1'b0;
         memReady = (i < 4);
         opcode = 6'b000000;
         #1;
         checks++;
         if (state !== 4'(st[i])) begin failures++; $display("FAIL rtype_state[%0d] got=%0d want=%0d", i, state, st[i]); end
         checks++;
         if (RegWrite !== (i == 3) || RegDst !== (i == 3)) begin
            failures++; $display("FAIL rtype_regwrite[%0d] got=%0b%0b want=%0b%0b", i, RegWrite, RegDst, i == 3, i == 3);
         end
         if (i == 0) begin
            checks++;
            if ({MemRead, IRWrite, PCWrite, ALUSrcB} !== 5'b11101) begin
               failures++; $display("FAIL rtype_fetch got=%b want=11101", {MemRead, IRWrite, PCWrite, ALUSrcB});
            end
         end
         if (i == 2) begin
            checks++;
            if ({ALUSrcA, ALUSrcB, ALUOp} !== 5'b10010) begin
               failures++; $display("FAIL rtype_exec got=%b want=10010", {ALUSrcA, ALUSrcB, ALUOp});
            end
         end
      end
      expCount++;
      checks++;
      if (instrCount !== expCount) begin failures++; $display("FAIL rtype_count got=%0d want=%0d", instrCount, expCount); end
   endtask

   task automatic test_lw_stall();
      int st[11] = '{0, 0, 0, 0, 1, 2, 3, 3, 3, 4, 0};
      bit mr[11] = '{0, 0, 0, 1, 1, 1, 0, 0, 1, 1, 0};
      int pulses = 0;
      for (int i = 0; i < 11; i++) begin
         @(negedge clk);
         memReady = mr[i];
         opcode = (i < 5) ? 6'b100011 : 6'b101011;
         #1;
         checks++;
         if (state !== 4'(st[i])) begin failures++; $display("FAIL lw_state[%0d] got=%0d want=%0d", i, state, st[i]); end
         if (i < 4) begin
            pulses += int'(IRWrite);
            checks++;
            if (IRWrite !== mr[i] || PCWrite !== mr[i] || MemRead !== 1'b1) begin
               failures++; $display("FAIL lw_fetch[%0d] got=%0b%0b%0b want=%0b%0b1", i, IRWrite, PCWrite, MemRead, mr[i], mr[i]);
            end
         end
         if (st[i] == 2) begin
            checks++;
            if ({ALUSrcA, ALUSrcB, ALUOp} !== 5'b11000) begin
               failures++; $display("FAIL lw_addr got=%b want=11000", {ALUSrcA, ALUSrcB, ALUOp});
            end
         end
         if (st[i] == 3) begin
            checks++;
            if ({MemRead, IorD, RegWrite} !== 3'b110) begin
               failures++; $display("FAIL lw_read[%0d] got=%b want=110", i, {MemRead, IorD, RegWrite});
            end
         end
         if (st[i] == 4) begin
            checks++;
            if ({RegWrite, MemtoReg, RegDst, MemRead} !== 4'b1100) begin
               failures++; $display("FAIL lw_wb got=%b want=1100", {RegWrite, MemtoReg, RegDst, MemRead});
            end
         end
      end
      checks++;
      if (pulses != 1) begin failures++; $display("FAIL lw_irwrite_pulses got=%0d want=1", pulses); end
      expCount++;
      checks++;
      if (instrCount !== expCount) begin failures++; $display("FAIL lw_count got=%0d want=%0d", instrCount, expCount); end
   endtask

   task automatic test_jump();
      int st[4] = '{0, 1, 9, 0};
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         memReady = (i < 3);
         opcode = 6'b000010;
         #1;
         checks++;
         if (state !== 4'(st[i])) begin failures++; $display("FAIL j_state[%0d] got=%0d want=%0d", i, state, st[i]); end
         if (i == 2) begin
            checks++;
            if ({PCWrite, PCSource, PCWriteCond, RegWrite} !== 5'b11000) begin
               failures++; $display("FAIL j_outputs got=%b want=11000", {PCWrite, PCSource, PCWriteCond, RegWrite});
            end
         end
      end
      expCount++;
      checks++;
      if (instrCount !== expCount) begin failures++; $display("FAIL j_count got=%0d want=%0d", instrCount, expCount); end
   endtask

   task automatic test_back_to_back();
      int st[8] = '{0, 1, 8, 0, 1, 2, 5, 0};
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         memReady = (i < 7);
         opcode = (i < 3) ? 6'b000100 : 6'b101011;
         #1;
         checks++;
         if (state !== 4'(st[i])) begin failures++; $display("FAIL b2b_state[%0d] got=%0d want=%0d", i, state, st[i]); end
         if (i == 2) begin
            checks++;
            if ({PCWriteCond, ALUOp, PCSource, ALUSrcA, PCWrite} !== 7'b1010110) begin
               failures++; $display("FAIL beq_outputs got=%b want=1010110", {PCWriteCond, ALUOp, PCSource, ALUSrcA, PCWrite});
            end
         end
         if (i == 3) begin
            checks++;
            if (instrCount !== expCount + 4'd1) begin failures++; $display("FAIL beq_count got=%0d want=%0d", instrCount, expCount + 4'd1); end
         end
         if (i == 6) begin
            checks++;
            if ({MemWrite, IorD, MemRead} !== 3'b110) begin
               failures++; $display("FAIL sw_outputs got=%b want=110", {MemWrite, IorD, MemRead});
            end
         end
      end
      expCount += 4'd2;
      checks++;
      if (instrCount !== expCount) begin failures++; $display("FAIL b2b_count got=%0d want=%0d", instrCount, expCount); end
   endtask

   task automatic test_illegal();
      int st[4] = '{0, 1, 0, 0};
      bit ill[4] = '{0, 0, 1, 0};
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         memReady = (i < 2);
         opcode = 6'b111111;
         #1;
         checks++;
         if (state !== 4'(st[i]) || illegalOp !== ill[i]) begin
            failures++; $display("FAIL illegal[%0d] got=%0d/%0b want=%0d/%0b", i, state, illegalOp, st[i], ill[i]);
         end
      end
      checks++;
      if (instrCount !== expCount) begin failures++; $display("FAIL illegal_count got=%0d want=%0d", instrCount, expCount); end
   endtask

   task automatic test_addi();
`ifdef ADDI_EN
      int st[5] = '{0, 1, 10, 11, 0};
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         memReady = (i < 4);
         opcode = 6'b001000;
         #1;
         checks++;
         if (state !== 4'(st[i]) || RegWrite !== (i == 3) || illegalOp !== 1'b0) begin
            failures++; $display("FAIL addi[%0d] got=%0d/%0b want=%0d/%0b", i, state, RegWrite, st[i], i == 3);
         end
         if (i == 2) begin
            checks++;
            if ({ALUSrcA, ALUSrcB} !== 3'b110) begin failures++; $display("FAIL addi_exec got=%b want=110", {ALUSrcA, ALUSrcB}); end
         end
      end
      expCount++;
`else
      int st[4] = '{0, 1, 0, 0};
      bit ill[4] = '{0, 0, 1, 0};
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         memReady = (i < 2);
         opcode = 6'b001000;
         #1;
         checks++;
         if (state !== 4'(st[i]) || illegalOp !== ill[i]) begin
            failures++; $display("FAIL addi_illegal[%0d] got=%0d/%0b want=%0d/%0b", i, state, illegalOp, st[i], ill[i]);
         end
      end
`endif
      checks++;
      if (instrCount !== expCount) begin failures++; $display("FAIL addi_count got=%0d want=%0d", instrCount, expCount); end
   endtask

   task automatic test_wrap();
      int st[3] = '{0, 1, 9};
      for (int i = 0; i <= 36; i++) begin
         @(negedge clk);
         memReady = (i < 36);
         opcode = 6'b000010;
         #1;
         checks++;
         if (state !== 4'(st[i % 3])) begin failures++; $display("FAIL wrap_state[%0d] got=%0d want=%0d", i, state, st[i % 3]); end
         if (i % 3 == 0 && i > 0) begin
            expCount++;
            checks++;
            if (instrCount !== expCount) begin failures++; $display("FAIL wrap_count[%0d] got=%0d want=%0d", i, instrCount, expCount); end
         end
      end
   endtask

   task automatic test_reset_mid();
      int st[7] = '{0, 1, 2, 3, 3, 3, 0};
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         memReady = (i < 3);
         reset = (i == 5);
         opcode = 6'b100011;
         #1;
         checks++;
         if (state !== 4'(st[i])) begin failures++; $display("FAIL rstmid_state[%0d] got=%0d want=%0d", i, state, st[i]); end
         checks++;
         if (RegWrite !== 1'b0) begin failures++; $display("FAIL rstmid_regwrite[%0d] got=%0b want=0", i, RegWrite); end
         if (i >= 3) begin
            checks++;
            if (MemRead !== (i != 5)) begin failures++; $display("FAIL rstmid_memread[%0d] got=%0b want=%0b", i, MemRead, i != 5); end
         end
      end
      expCount = 4'd0;
      checks++;
      if (instrCount !== expCount || illegalOp !== 1'b0) begin
         failures++; $display("FAIL rstmid_count got=%0d/%0b want=0/0", instrCount, illegalOp);
      end
   endtask

   initial begin
      test_reset();
      test_rtype();
      test_lw_stall();
      test_jump();
      test_back_to_back();
      test_illegal();
      test_addi();
      test_wrap();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
